// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch queue.
//   fetch_state_e : request FSM states (IDLE, WAIT, DISCARD)
//   ADDR_W_DEF    : default PC / address width
//   INSTR_W_DEF   : default instruction width
//   fetch_entry_t : layout of one buffered entry at the default widths;
//                   the FIFO stores the same {pc, instr} packing as a flat vector
package fetch_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with registered storage.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   clear_i    : empties the FIFO at the next edge, overriding push/pop
//   push_i     : write wdata_i (ignored when full and not popping)
//   wdata_i    : entry to write
//   pop_i      : drop head entry (ignored when empty)
//   rdata_o    : head entry (contents undefined when empty)
//   count_o    : number of stored entries, 0..DEPTH
//   empty_o    : no entries stored
module fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC stage and decode.
//   clk, rst    : clock, synchronous active-high reset
//   pc_in       : current PC from the PC stage
//   pc_advance  : one-cycle pulse when pc_in is taken for fetch
//   flush       : redirect; kills the pending request result and all buffered entries
//   imem_req    : read request level, held until imem_ack
//   imem_addr   : word-aligned request address, stable while imem_req
//   imem_ack    : one-cycle data-valid pulse from instruction memory
//   imem_rdata  : instruction word, valid with imem_ack
//   dec_valid   : FIFO head valid
//   dec_instr   : head instruction (0 when dec_valid = 0)
//   dec_pc      : PC of head instruction (0 when dec_valid = 0)
//   dec_ready   : decode consumes the head when dec_valid & dec_ready
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                issue;
  logic                fifo_push;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
  logic                slot_free;

  // The request about to be issued reserves a FIFO slot up front, so the
  // returning word can always be pushed without back-pressuring memory.
  assign slot_free = (fifo_count + CW'(1)) <= DEPTH_C;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issue     = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && !flush && slot_free) begin
          issue   = 1'b1;
          pc_d    = pc_in;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          fifo_push = ~flush;
          state_d   = IDLE;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // Memory still owes us a beat; keep requesting and throw it away.
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_advance = issue;
  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = {pc_q[ADDR_W-1:2], 2'b00};

  // Entries keep the original (possibly misaligned) PC alongside the word.
  assign fifo_wdata = {pc_q, imem_rdata};

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (dec_ready),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign dec_valid = ~fifo_empty;
  assign dec_pc    = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:INSTR_W];
  assign dec_instr = fifo_empty ? '0 : fifo_rdata[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_ready;

  int          vectors = 0;
  int          miscompares = 0;
  int          cnt = 0;
  int          lat = 1;
  bit          rnd_lat = 1'b0;
  bit          sb_en = 1'b0;
  int          n_pops = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_advance (pc_advance),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready)
  );

  // Memory content: 0x00A00093 at address 40, distinct words elsewhere.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    logic [31:0] d;
    d = a[31:0] - 32'd40;
    return 32'h00A00093 ^ (d << 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then after the rising edge update the
  // PC-stage model and the memory model (ack lat cycles after req is seen).
  task automatic tick();
    logic        adv_s, req_s, rst_s, pop_s, ack_was;
    logic [63:0] addr_s, pcin_s, dpc_s, e;
    logic [31:0] dinst_s;
    @(negedge clk);
    adv_s   = pc_advance;
    req_s   = imem_req;
    rst_s   = rst;
    addr_s  = imem_addr;
    pcin_s  = pc_in;
    pop_s   = dec_valid & dec_ready;
    dpc_s   = dec_pc;
    dinst_s = dec_instr;
    if (sb_en) begin
      if (adv_s) exp_q.push_back(pcin_s);
      if (pop_s) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          chk("rand_spurious_pop", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_pc", dpc_s, e);
          chk("rand_instr", {32'd0, dinst_s}, {32'd0, instr_of(e & ~64'd3)});
        end
      end
      chk("rand_occupancy", {63'd0, (exp_q.size() <= 4)}, 64'd1);
    end
    @(posedge clk);
    #1;
    if (adv_s) pc_in = pc_in + 64'd4;
    ack_was  = imem_ack;
    imem_ack = 1'b0;
    if (rst_s) begin
      cnt = 0;
    end else if (req_s && !ack_was) begin
      cnt++;
      if (cnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = instr_of(addr_s);
        cnt        = 0;
        if (rnd_lat) lat = $urandom_range(1, 5);
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    pc_in      = 64'd40;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    dec_ready  = 1'b0;
    lat        = 1;

    // Reset values
    tick();
    tick();
    chk("rst_pc_advance", {63'd0, pc_advance}, 64'd0);
    chk("rst_imem_req",   {63'd0, imem_req},   64'd0);
    chk("rst_imem_addr",  imem_addr,           64'd0);
    chk("rst_dec_valid",  {63'd0, dec_valid},  64'd0);
    chk("rst_dec_instr",  {32'd0, dec_instr},  64'd0);
    chk("rst_dec_pc",     dec_pc,              64'd0);

    // First fetch after release, then fill with dec_ready = 0
    rst = 1'b0;
    #1;
    chk("t0_pc_advance", {63'd0, pc_advance}, 64'd1);
    tick();
    chk("t1_imem_req",    {63'd0, imem_req},   64'd1);
    chk("t1_imem_addr",   imem_addr,           64'd40);
    chk("t1_pc_advance",  {63'd0, pc_advance}, 64'd0);
    tick();
    chk("t2_dec_valid",   {63'd0, dec_valid},  64'd0);
    tick();
    chk("t3_dec_valid",   {63'd0, dec_valid},  64'd1);
    chk("t3_dec_pc",      dec_pc,              64'd40);
    chk("t3_dec_instr",   {32'd0, dec_instr},  64'h00A00093);
    for (int i = 0; i < 9; i++) tick();
    chk("full_pc_advance", {63'd0, pc_advance}, 64'd0);
    chk("full_imem_req",   {63'd0, imem_req},   64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("hold_pc_advance", {63'd0, pc_advance}, 64'd0);
    chk("hold_imem_req",   {63'd0, imem_req},   64'd0);
    chk("hold_pc_in",      pc_in,               64'd56);

    // Drain in order; the refetch of 56 lands while 52 is popped
    dec_ready = 1'b1;
    #1;
    chk("drain0_pc",    dec_pc,             64'd40);
    tick();
    chk("drain1_pc",    dec_pc,             64'd44);
    chk("drain1_instr", {32'd0, dec_instr}, 64'h00A00493);
    chk("drain1_adv",   {63'd0, pc_advance}, 64'd1);
    tick();
    chk("drain2_pc",    dec_pc,             64'd48);
    chk("drain2_instr", {32'd0, dec_instr}, 64'h00A00893);
    tick();
    chk("drain3_pc",    dec_pc,             64'd52);
    chk("drain3_instr", {32'd0, dec_instr}, 64'h00A00C93);
    tick();
    chk("drain4_valid", {63'd0, dec_valid}, 64'd1);
    chk("drain4_pc",    dec_pc,             64'd56);
    chk("drain4_instr", {32'd0, dec_instr}, 64'h00A01093);

    // Flush while waiting; late ack must be discarded
    dec_ready = 1'b0;
    pc_in     = 64'h80;
    lat       = 3;
    do_reset();
    chk("fw_t0_adv", {63'd0, pc_advance}, 64'd1);
    tick();
    flush = 1'b1;
    pc_in = 64'h100;
    #1;
    chk("fw_flush_adv", {63'd0, pc_advance}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fw_discard_req",   {63'd0, imem_req},   64'd1);
    chk("fw_discard_valid", {63'd0, dec_valid},  64'd0);
    chk("fw_discard_adv",   {63'd0, pc_advance}, 64'd0);
    tick();
    chk("fw_t3_adv", {63'd0, pc_advance}, 64'd0);
    tick();
    chk("fw_ack_req", {63'd0, imem_req},   64'd1);
    chk("fw_ack_adv", {63'd0, pc_advance}, 64'd0);
    lat = 1;
    tick();
    chk("fw_post_valid", {63'd0, dec_valid},  64'd0);
    chk("fw_post_adv",   {63'd0, pc_advance}, 64'd1);
    tick();
    chk("fw_new_addr", imem_addr, 64'h100);
    tick();
    tick();
    chk("fw_new_valid", {63'd0, dec_valid}, 64'd1);
    chk("fw_new_pc",    dec_pc,             64'h100);
    chk("fw_new_instr", {32'd0, dec_instr}, 64'h00A0D893);

    // Flush coinciding with ack, two entries buffered
    pc_in = 64'd40;
    lat   = 1;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    flush = 1'b1;
    #1;
    chk("fa_pre_valid", {63'd0, dec_valid}, 64'd1);
    chk("fa_pre_pc",    dec_pc,             64'd40);
    chk("fa_ack_seen",  {63'd0, imem_req},  64'd1);
    tick();
    flush = 1'b0;
    pc_in = 64'h200;
    #1;
    chk("fa_post_valid", {63'd0, dec_valid},  64'd0);
    chk("fa_post_req",   {63'd0, imem_req},   64'd0);
    chk("fa_post_adv",   {63'd0, pc_advance}, 64'd1);
    tick();
    chk("fa_new_addr", imem_addr, 64'h200);
    tick();
    tick();
    chk("fa_new_pc",    dec_pc,             64'h200);
    chk("fa_new_instr", {32'd0, dec_instr}, 64'h00A1D893);

    // Misaligned PC
    pc_in = 64'h2E;
    do_reset();
    tick();
    chk("mis_addr", imem_addr, 64'h2C);
    tick();
    tick();
    chk("mis_dec_pc",    dec_pc,             64'h2E);
    chk("mis_dec_instr", {32'd0, dec_instr}, 64'h00A00493);

    // Random ack latency and decode back-pressure
    pc_in   = 64'h1000;
    rnd_lat = 1'b1;
    lat     = $urandom_range(1, 5);
    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      dec_ready = ($urandom_range(0, 2) != 0);
    end
    sb_en = 1'b0;
    chk("rand_progress", {63'd0, (n_pops > 100)}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
